ex_alu_stage: RTL

- Execute-stage ALU plus EX/MEM pipeline register for the pipelined MIPS core.
- Consumes the 4-bit ALU control code from the ALU controller, two 32-bit operands and branch/writeback sideband from ID/EX.
- Produces a registered result, flags and branch resolution for the MEM stage.
- Supports downstream stall (hold), flush (bubble insert) and an illegal-op flag for unsupported control codes.

---
 rtl/ex_alu_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU and EX/MEM pipeline register: combinational ALU feeding a
// single registered stage with hold (stall), bubble insert (flush) and illegal-op tagging.
module ex_alu_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [3:0]        alu_ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              branch_i,
    input  logic              reg_write_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              illegal_o,
    output logic              branch_taken_o,
    output logic              reg_write_o,
    output logic [REG_W-1:0]  rd_o
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;
    logic              alu_illegal;
    logic              alu_zero;

    assign sum  = src1_i + src2_i;
    assign diff = src1_i - src2_i;

    assign add_ovf = ~(src1_i[MSB] ^ src2_i[MSB]) & (sum[MSB] ^ src1_i[MSB]);
    assign sub_ovf =  (src1_i[MSB] ^ src2_i[MSB]) & (diff[MSB] ^ src1_i[MSB]);

    always_comb begin
        alu_result  = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (alu_ctrl_i)
            ALU_AND: alu_result = src1_i & src2_i;
            ALU_OR:  alu_result = src1_i | src2_i;
            ALU_ADD: begin
                alu_result = sum;
                alu_ovf    = add_ovf;
            end
            ALU_SUB: begin
                alu_result = diff;
                alu_ovf    = sub_ovf;
            end
            // Signed less-than stays correct even when A-B wraps.
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, diff[MSB] ^ sub_ovf};
            default: alu_illegal = 1'b1;
        endcase
    end

    assign alu_zero = (alu_result == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o        <= 1'b0;
            result_o       <= '0;
            zero_o         <= 1'b0;
            overflow_o     <= 1'b0;
            illegal_o      <= 1'b0;
            branch_taken_o <= 1'b0;
            reg_write_o    <= 1'b0;
            rd_o           <= '0;
        end else if (stall_i) begin
            valid_o        <= valid_o;
            result_o       <= result_o;
            zero_o         <= zero_o;
            overflow_o     <= overflow_o;
            illegal_o      <= illegal_o;
            branch_taken_o <= branch_taken_o;
            reg_write_o    <= reg_write_o;
            rd_o           <= rd_o;
        end else if (flush_i || !valid_i) begin
            valid_o        <= 1'b0;
            result_o       <= '0;
            zero_o         <= 1'b0;
            overflow_o     <= 1'b0;
            illegal_o      <= 1'b0;
            branch_taken_o <= 1'b0;
            reg_write_o    <= 1'b0;
            rd_o           <= '0;
        end else begin
            valid_o        <= 1'b1;
            result_o       <= alu_result;
            zero_o         <= alu_zero;
            overflow_o     <= alu_ovf;
            illegal_o      <= alu_illegal;
            branch_taken_o <= branch_i & alu_zero;
            // Overflowing or illegal ops must never reach the register file.
            reg_write_o    <= reg_write_i & ~alu_illegal & ~alu_ovf;
            rd_o           <= rd_i;
        end
    end

endmodule
